int_ctl: RTL and testbench
==========================

// Module: int_ctl
// PURPOSE
//  Single-level interrupt controller for the 8-bit core. Synchronises the external irq pin and latches requests.
//  Takes an interrupt at an instruction boundary: saves the return PC and the live cc_c/cc_z flags, then redirects fetch to a fixed vector.
//  Feeds int_c/int_z back to the condition-code unit, which restores them on RETI (kind==4'b1000).
//  Sits beside fetch/decode, upstream of the condition-code unit.
// PARAMETERS
//  VEC_ADDR     8'hF0  interrupt vector driven on vec_addr during int_take
//  SYNC_STAGES  2      irq synchroniser depth; legal values 2 or 3
// PORTS
//  ck        in   1  clock; all state changes on posedge ck
//  res       in   1  reset, synchronous, active-high
//  ck2       in   1  phase qualifier; state advances only on edges where ck2==0
//  bound     in   1  1 = current instruction completes this phase (legal accept point)
//  kind      in   4  decoded class: 4'b1000 RETI, 4'b1001 EI, 4'b1010 DI, other = no effect
//  pc        in   8  address of next instruction (return address)
//  cc_c      in   1  current carry flag from condition-code unit
//  cc_z      in   1  current zero flag from condition-code unit
//  irq       in   1  asynchronous external request, rising-edge sensitive
//  int_take  out  1  one-cycle pulse: fetch loads vec_addr
//  vec_addr  out  8  VEC_ADDR when int_take, else 8'h00
//  int_pc    out  8  saved return PC
//  int_c     out  1  saved carry
//  int_z     out  1  saved zero
//  ie        out  1  interrupt enable
//  in_svc    out  1  1 while the handler runs (state SERVICE)
//  pend      out  1  latched request waiting
//  lost_cnt  out  4  dropped-request count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (res==1 at posedge ck, regardless of ck2): state IDLE; sync chain, pend, ie, in_svc, int_take, int_pc, int_c, int_z, lost_cnt all 0.
//  Edge detect: rise = sync_out & ~sync_prev. It is sampled every clock, not gated by ck2. Latency is irq pin to pend: SYNC_STAGES+1 clocks.
//  Any rise sets pend. pend clears only on accept.
//  A rise while pend==1 is a dropped request. The rise and its accept falling on the same edge do not count as dropped; pend stays 1.
//  ENABLE updates (ck2==0 edge): EI sets ie; DI clears ie. DI on the same edge as a possible accept blocks the accept.
//  FSM, advancing only on ck2==0 edges:
//   IDLE -> ACCEPT when pend & ie & bound & kind!=DI.
//   ACCEPT (exactly one clock, not gated by ck2): int_take=1, vec_addr=VEC_ADDR.
//    Captures int_pc<=pc, int_c<=cc_c, int_z<=cc_z (values present at the IDLE->ACCEPT edge).
//    Clears pend and ie. Next state is SERVICE.
//   SERVICE: in_svc=1. EI/DI are ignored; ie stays 0 (no nesting).
//    RETI on a ck2==0 edge -> IDLE with ie<=1. The saved int_* values hold until the next accept.
//  Simultaneous events:
//   RETI with pend==1: return to IDLE first. Accept on the next qualifying ck2==0 edge, never the same edge.
//   Rise during ACCEPT or SERVICE: sets pend and is served after RETI.
//  int_pc/int_c/int_z change only in ACCEPT. They are stable whenever the CC unit samples them on RETI.
//  Reset mid-SERVICE: immediate IDLE, ie=0. A pending request is discarded.
//  No arithmetic except lost_cnt, which saturates at 4'hF (no wrap).
// CONFIGURATION
//  INT_LOST_CNT_EN defined: lost_cnt counts dropped requests, saturating at 15. It is cleared only by res.
//  INT_LOST_CNT_EN undefined: no counter logic; lost_cnt tied to 4'h0.
// TESTING
//  1 Reset: res=1 for 2 clk -> every output 0, state IDLE; irq pulses with ie=0 -> pend=1, int_take never asserts.
//  2 Basic take: EI, pc=8'h3A, cc_c=1, cc_z=0, irq rise, bound=1 -> pend at SYNC_STAGES+1 clk.
//    Then int_take 1 clk with vec_addr=8'hF0; int_pc=8'h3A, int_c=1, int_z=0; in_svc=1, ie=0, pend=0.
//  3 RETI: in SERVICE drive kind=4'b1000 on ck2==0 edge -> in_svc=0, ie=1; int_pc/int_c/int_z unchanged.
//  4 Queued request: irq rise during SERVICE -> pend=1, no take.
//    RETI -> IDLE, then int_take on the following qualifying edge, not the RETI edge.
//  5 DI race: pend=1, ie=1, bound=1, kind=4'b1010 on the same ck2==0 edge -> no int_take, ie=0, pend stays 1.
//  6 Drops (INT_LOST_CNT_EN): 20 irq rises while pend=1 and ie=0 -> lost_cnt=4'hF. Without the macro -> lost_cnt=0.
//  Also: res asserted mid-SERVICE -> next clock IDLE, ie=0, pend=0.

Source files
------------

// File: rtl/int_ctl.sv
// ============================================================================
// Module      : int_ctl
// Description : Single-level interrupt controller. Synchronises and latches
//               irq, takes it at an instruction boundary, saves PC and C/Z,
//               redirects fetch to VEC_ADDR and supports RETI.
//               Optional macro INT_LOST_CNT_EN enables the dropped-request
//               counter on lost_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctl #(
    parameter logic [7:0] VEC_ADDR    = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       ck,
    input  logic       res,
    input  logic       ck2,
    input  logic       bound,
    input  logic [3:0] kind,
    input  logic [7:0] pc,
    input  logic       cc_c,
    input  logic       cc_z,
    input  logic       irq,
    output logic       int_take,
    output logic [7:0] vec_addr,
    output logic [7:0] int_pc,
    output logic       int_c,
    output logic       int_z,
    output logic       ie,
    output logic       in_svc,
    output logic       pend,
    output logic [3:0] lost_cnt
);

    localparam logic [3:0] C_KIND_RETI = 4'b1000;
    localparam logic [3:0] C_KIND_EI   = 4'b1001;
    localparam logic [3:0] C_KIND_DI   = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCEPT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_pend;
    logic                   r_ie;
    logic                   r_in_svc;
    logic                   r_int_take;
    logic [7:0]             r_vec_addr;
    logic [7:0]             r_int_pc;
    logic                   r_int_c;
    logic                   r_int_z;
    logic                   w_rise;
    logic                   w_accept;

    assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    // A DI on the accept edge wins over the request.
    assign w_accept = (r_state == S_IDLE) & ~ck2 & r_pend & r_ie & bound
                      & (kind != C_KIND_DI);

    always_ff @(posedge ck) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_pend      <= 1'b0;
            r_ie        <= 1'b0;
            r_in_svc    <= 1'b0;
            r_int_take  <= 1'b0;
            r_vec_addr  <= 8'h00;
            r_int_pc    <= 8'h00;
            r_int_c     <= 1'b0;
            r_int_z     <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], irq};
            r_sync_prev <= r_sync[SYNC_STAGES-1];

            // A rise coinciding with the accept re-arms pend immediately.
            if (w_accept)
                r_pend <= w_rise;
            else if (w_rise)
                r_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (!ck2) begin
                        if (w_accept) begin
                            r_state    <= S_ACCEPT;
                            r_int_take <= 1'b1;
                            r_vec_addr <= VEC_ADDR;
                            r_int_pc   <= pc;
                            r_int_c    <= cc_c;
                            r_int_z    <= cc_z;
                            r_ie       <= 1'b0;
                        end else if (kind == C_KIND_EI) begin
                            r_ie <= 1'b1;
                        end else if (kind == C_KIND_DI) begin
                            r_ie <= 1'b0;
                        end
                    end
                end
                S_ACCEPT: begin
                    r_state    <= S_SERVICE;
                    r_int_take <= 1'b0;
                    r_vec_addr <= 8'h00;
                    r_in_svc   <= 1'b1;
                end
                S_SERVICE: begin
                    if (!ck2 && kind == C_KIND_RETI) begin
                        r_state  <= S_IDLE;
                        r_in_svc <= 1'b0;
                        r_ie     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INT_LOST_CNT_EN
    logic [3:0] r_lost_cnt;

    always_ff @(posedge ck) begin
        if (res)
            r_lost_cnt <= 4'h0;
        else if (w_rise && r_pend && !w_accept && r_lost_cnt != 4'hF)
            r_lost_cnt <= r_lost_cnt + 4'h1;
    end

    assign lost_cnt = r_lost_cnt;
`else
    assign lost_cnt = 4'h0;
`endif

    assign int_take = r_int_take;
    assign vec_addr = r_vec_addr;
    assign int_pc   = r_int_pc;
    assign int_c    = r_int_c;
    assign int_z    = r_int_z;
    assign ie       = r_ie;
    assign in_svc   = r_in_svc;
    assign pend     = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_int_ctl.sv
// ============================================================================
// Module      : tb_int_ctl
// Description : Directed self-checking bench for int_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctl;

    localparam logic [3:0] C_RETI = 4'b1000;
    localparam logic [3:0] C_EI   = 4'b1001;
    localparam logic [3:0] C_DI   = 4'b1010;
    localparam logic [3:0] C_NOP  = 4'b0000;

    logic       clk = 1'b0;
    logic       res;
    logic       ck2;
    logic       bound;
    logic [3:0] kind;
    logic [7:0] pc;
    logic       cc_c;
    logic       cc_z;
    logic       irq;
    logic       int_take;
    logic [7:0] vec_addr;
    logic [7:0] int_pc;
    logic       int_c;
    logic       int_z;
    logic       ie;
    logic       in_svc;
    logic       pend;
    logic [3:0] lost_cnt;

    int n_chk = 0;
    int n_bad = 0;

    int_ctl #(.VEC_ADDR(8'hF0), .SYNC_STAGES(2)) u_dut (
        .ck       (clk),
        .res      (res),
        .ck2      (ck2),
        .bound    (bound),
        .kind     (kind),
        .pc       (pc),
        .cc_c     (cc_c),
        .cc_z     (cc_z),
        .irq      (irq),
        .int_take (int_take),
        .vec_addr (vec_addr),
        .int_pc   (int_pc),
        .int_c    (int_c),
        .int_z    (int_z),
        .ie       (ie),
        .in_svc   (in_svc),
        .pend     (pend),
        .lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic irq_pulse;
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
    endtask

    initial begin
        res = 1'b1; ck2 = 1'b0; bound = 1'b0; kind = C_NOP;
        pc = 8'h00; cc_c = 1'b0; cc_z = 1'b0; irq = 1'b0;
        tick();
        tick();
        chk("rst_take",   {31'd0, int_take}, 0);
        chk("rst_vec",    {24'd0, vec_addr}, 0);
        chk("rst_pc",     {24'd0, int_pc},   0);
        chk("rst_cz",     {30'd0, int_c, int_z}, 0);
        chk("rst_ie",     {31'd0, ie},       0);
        chk("rst_svc",    {31'd0, in_svc},   0);
        chk("rst_pend",   {31'd0, pend},     0);
        chk("rst_lost",   {28'd0, lost_cnt}, 0);
        res = 1'b0;

        // irq with ie=0: pend after SYNC_STAGES+1 clocks, never taken
        bound = 1'b1;
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
        chk("lat_pend0",  {31'd0, pend},     0);
        tick();
        chk("lat_pend1",  {31'd0, pend},     1);
        tick();
        chk("noie_take",  {31'd0, int_take}, 0);

        // EI with no boundary: enable only
        bound = 1'b0; kind = C_EI;
        tick();
        chk("ei_ie",      {31'd0, ie},       1);
        chk("ei_notake",  {31'd0, int_take}, 0);

        // DI racing a possible accept
        bound = 1'b1; kind = C_DI;
        tick();
        chk("di_take",    {31'd0, int_take}, 0);
        chk("di_ie",      {31'd0, ie},       0);
        chk("di_pend",    {31'd0, pend},     1);

        // ck2==1 gates the enable update
        bound = 1'b0; kind = C_EI; ck2 = 1'b1;
        tick();
        chk("ck2_gate",   {31'd0, ie},       0);
        ck2 = 1'b0;
        tick();
        chk("ck2_open",   {31'd0, ie},       1);

        // basic take
        kind = C_NOP; pc = 8'h3A; cc_c = 1'b1; cc_z = 1'b0; bound = 1'b1;
        tick();
        chk("take_pulse", {31'd0, int_take}, 1);
        chk("take_vec",   {24'd0, vec_addr}, 32'hF0);
        chk("take_pc",    {24'd0, int_pc},   32'h3A);
        chk("take_cz",    {30'd0, int_c, int_z}, 32'h2);
        chk("take_ie",    {31'd0, ie},       0);
        chk("take_pend",  {31'd0, pend},     0);
        pc = 8'h55; cc_c = 1'b0; cc_z = 1'b1;
        tick();
        chk("svc_take",   {31'd0, int_take}, 0);
        chk("svc_vec",    {24'd0, vec_addr}, 0);
        chk("svc_in",     {31'd0, in_svc},   1);
        chk("svc_pc",     {24'd0, int_pc},   32'h3A);

        // EI ignored in SERVICE
        kind = C_EI;
        tick();
        chk("svc_ei",     {31'd0, ie},       0);
        kind = C_NOP;

        // request queued during SERVICE
        irq_pulse();
        tick();
        chk("q_pend",     {31'd0, pend},     1);
        chk("q_notake",   {31'd0, int_take}, 0);

        // RETI on a ck2==1 edge does nothing
        kind = C_RETI; ck2 = 1'b1;
        tick();
        chk("reti_gate",  {31'd0, in_svc},   1);
        ck2 = 1'b0;
        tick();
        chk("reti_svc",   {31'd0, in_svc},   0);
        chk("reti_ie",    {31'd0, ie},       1);
        chk("reti_take",  {31'd0, int_take}, 0);
        chk("reti_pc",    {24'd0, int_pc},   32'h3A);
        chk("reti_cz",    {30'd0, int_c, int_z}, 32'h2);
        kind = C_NOP;
        tick();
        chk("q_take",     {31'd0, int_take}, 1);
        chk("q_pc",       {24'd0, int_pc},   32'h55);
        chk("q_cz",       {30'd0, int_c, int_z}, 32'h1);
        tick();
        chk("q_svc",      {31'd0, in_svc},   1);

        // reset mid-SERVICE with a pending request
        irq_pulse();
        tick();
        chk("mid_pend",   {31'd0, pend},     1);
        res = 1'b1;
        tick();
        res = 1'b0;
        chk("mid_svc",    {31'd0, in_svc},   0);
        chk("mid_ie",     {31'd0, ie},       0);
        chk("mid_pend0",  {31'd0, pend},     0);
        chk("mid_pc",     {24'd0, int_pc},   0);

        // dropped requests with ie=0
        irq_pulse();
        tick();
        tick();
        chk("drop_pend",  {31'd0, pend},     1);
        chk("drop_cnt0",  {28'd0, lost_cnt}, 0);
        for (int i = 0; i < 3; i++) irq_pulse();
        tick();
        tick();
`ifdef INT_LOST_CNT_EN
        chk("drop_cnt3",  {28'd0, lost_cnt}, 3);
`else
        chk("drop_cnt3",  {28'd0, lost_cnt}, 0);
`endif
        for (int i = 0; i < 20; i++) irq_pulse();
        tick();
        tick();
`ifdef INT_LOST_CNT_EN
        chk("drop_sat",   {28'd0, lost_cnt}, 15);
`else
        chk("drop_sat",   {28'd0, lost_cnt}, 0);
`endif
        chk("drop_notake", {31'd0, int_take}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
